// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO register file: register offsets, CTRL bit indices, bus width.
package gpio_pkg;

  localparam int unsigned GPIO_DW = 32;

  localparam logic [2:0] GPIO_IN_OFS    = 3'd0;
  localparam logic [2:0] GPIO_OUT_OFS   = 3'd1;
  localparam logic [2:0] GPIO_OE_OFS    = 3'd2;
  localparam logic [2:0] GPIO_INTE_OFS  = 3'd3;
  localparam logic [2:0] GPIO_PTRIG_OFS = 3'd4;
  localparam logic [2:0] GPIO_CTRL_OFS  = 3'd5;
  localparam logic [2:0] GPIO_INTS_OFS  = 3'd6;

  localparam int unsigned CTRL_IE_BIT   = 0;
  localparam int unsigned CTRL_INTS_BIT = 1;

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad-input synchroniser followed by a history flop; reports per-line rising and falling edges.
module gpio_sync_edge #(
  parameter int unsigned GPIO_W   = 32,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [GPIO_W-1:0] pad_i,
  output logic [GPIO_W-1:0] sync_o,
  output logic [GPIO_W-1:0] rise_o,
  output logic [GPIO_W-1:0] fall_o
);

  logic [SYNC_STG-1:0][GPIO_W-1:0] sync_q;
  logic [GPIO_W-1:0]               prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], pad_i};
      prev_q <= sync_q[SYNC_STG-1];
    end
  end

  assign sync_o = sync_q[SYNC_STG-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/gpio_regs.sv
// GPIO register file behind the APB slave: pad output/enable, edge-triggered interrupt status,
// zero-latency read mux and a registered level interrupt.
module gpio_regs
  import gpio_pkg::*;
#(
  parameter int unsigned GPIO_W   = 32,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               gpio_we,
  input  logic [GPIO_DW-1:0] gpio_addr,
  input  logic [GPIO_DW-1:0] gpio_dat_i,
  output logic [GPIO_DW-1:0] gpio_dat_o,
  output logic               gpio_int_o,
  input  logic [GPIO_W-1:0]  gpio_in,
  output logic [GPIO_W-1:0]  gpio_out,
  output logic [GPIO_W-1:0]  gpio_oe
);

  logic [GPIO_W-1:0] out_q, out_d, oe_q, oe_d, inte_q, inte_d, ptrig_q, ptrig_d;
  logic [GPIO_W-1:0] ints_q, ints_d, ints_clr, ints_set;
  logic [GPIO_W-1:0] in_sync, in_rise, in_fall, wdata;
  logic              ie_q, ie_d, irq_q, irq_d;
  logic [2:0]        ofs;
  logic              unused_bits;

  assign ofs         = gpio_addr[4:2];
  assign wdata       = gpio_dat_i[GPIO_W-1:0];
  assign unused_bits = ^{gpio_addr[31:5], gpio_addr[1:0], gpio_dat_i};

  gpio_sync_edge #(
    .GPIO_W  (GPIO_W),
    .SYNC_STG(SYNC_STG)
  ) u_sync_edge (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .pad_i (gpio_in),
    .sync_o(in_sync),
    .rise_o(in_rise),
    .fall_o(in_fall)
  );

  assign ints_set = inte_q & ((ptrig_q & in_rise) | (~ptrig_q & in_fall));

  always_comb begin
    out_d    = out_q;
    oe_d     = oe_q;
    inte_d   = inte_q;
    ptrig_d  = ptrig_q;
    ie_d     = ie_q;
    ints_clr = '0;
    if (gpio_we) begin
      case (ofs)
        GPIO_OUT_OFS:   out_d    = wdata;
        GPIO_OE_OFS:    oe_d     = wdata;
        GPIO_INTE_OFS:  inte_d   = wdata;
        GPIO_PTRIG_OFS: ptrig_d  = wdata;
        GPIO_CTRL_OFS:  ie_d     = gpio_dat_i[CTRL_IE_BIT];
        GPIO_INTS_OFS:  ints_clr = wdata;
        default: ;
      endcase
    end
    // A new edge outranks a same-cycle W1C on that bit.
    ints_d = (ints_q & ~ints_clr) | ints_set;
    irq_d  = ie_q & (|ints_q);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      out_q   <= '0;
      oe_q    <= '0;
      inte_q  <= '0;
      ptrig_q <= '0;
      ie_q    <= 1'b0;
      ints_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      oe_q    <= oe_d;
      inte_q  <= inte_d;
      ptrig_q <= ptrig_d;
      ie_q    <= ie_d;
      ints_q  <= ints_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    gpio_dat_o = '0;
    case (ofs)
      GPIO_IN_OFS:    gpio_dat_o[GPIO_W-1:0] = in_sync;
      GPIO_OUT_OFS:   gpio_dat_o[GPIO_W-1:0] = out_q;
      GPIO_OE_OFS:    gpio_dat_o[GPIO_W-1:0] = oe_q;
      GPIO_INTE_OFS:  gpio_dat_o[GPIO_W-1:0] = inte_q;
      GPIO_PTRIG_OFS: gpio_dat_o[GPIO_W-1:0] = ptrig_q;
      GPIO_CTRL_OFS: begin
        gpio_dat_o[CTRL_IE_BIT]   = ie_q;
        gpio_dat_o[CTRL_INTS_BIT] = |ints_q;
      end
      GPIO_INTS_OFS:  gpio_dat_o[GPIO_W-1:0] = ints_q;
      default: ;
    endcase
  end

  assign gpio_out   = out_q;
  assign gpio_oe    = oe_q;
  assign gpio_int_o = irq_q;

endmodule

// File: tb/tb_gpio_regs.sv
// Randomised and directed bench for gpio_regs against a delay-line/register-map reference model.
`timescale 1ns / 1ps
module tb_gpio_regs;

  localparam int unsigned GPIO_W   = 32;
  localparam int unsigned SYNC_STG = 2;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              gpio_we = 1'b0;
  logic [31:0]       gpio_addr = '0;
  logic [31:0]       gpio_dat_i = '0;
  logic [31:0]       gpio_dat_o;
  logic              gpio_int_o;
  logic [GPIO_W-1:0] gpio_in = '0;
  logic [GPIO_W-1:0] gpio_out;
  logic [GPIO_W-1:0] gpio_oe;

  gpio_regs #(
    .GPIO_W  (GPIO_W),
    .SYNC_STG(SYNC_STG)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .gpio_we   (gpio_we),
    .gpio_addr (gpio_addr),
    .gpio_dat_i(gpio_dat_i),
    .gpio_dat_o(gpio_dat_o),
    .gpio_int_o(gpio_int_o),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .gpio_oe   (gpio_oe)
  );

  always #50 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain register values plus a queue of pad samples, one per clock edge.
  logic [31:0] m_out, m_oe, m_inte, m_ptrig, m_ints;
  logic        m_ie, m_irq;
  logic [31:0] m_pads[$];
  logic [31:0] mask;

  task automatic m_reset();
    m_out = 0; m_oe = 0; m_inte = 0; m_ptrig = 0; m_ints = 0; m_ie = 0; m_irq = 0;
    m_pads.delete();
    for (int i = 0; i <= SYNC_STG; i++) m_pads.push_back('0);
  endtask

  // Oldest queue entry is the previous synced value, next one is the current synced value.
  function automatic logic [31:0] m_read(input int ofs);
    case (ofs)
      0: return m_pads[1];
      1: return m_out;
      2: return m_oe;
      3: return m_inte;
      4: return m_ptrig;
      5: return {30'd0, m_ints != 0, m_ie};
      6: return m_ints;
      default: return 0;
    endcase
  endfunction

  task automatic m_edge();
    logic [31:0] s, p, rise, fall, set, w;
    int ofs;
    s = m_pads[1];
    p = m_pads[0];
    rise = s & ~p;
    fall = ~s & p;
    set = 0;
    for (int i = 0; i < int'(GPIO_W); i++)
      if (m_inte[i] && (m_ptrig[i] ? rise[i] : fall[i])) set[i] = 1'b1;
    m_irq = m_ie && (m_ints != 0);
    w = gpio_dat_i & mask;
    ofs = int'(gpio_addr[4:2]);
    if (gpio_we) begin
      if (ofs == 1) m_out = w;
      if (ofs == 2) m_oe = w;
      if (ofs == 3) m_inte = w;
      if (ofs == 4) m_ptrig = w;
      if (ofs == 5) m_ie = gpio_dat_i[0];
      if (ofs == 6) m_ints = m_ints & ~w;
    end
    m_ints = m_ints | set;
    m_pads.push_back(32'(gpio_in));
    void'(m_pads.pop_front());
  endtask

  task automatic read(input int ofs, output logic [31:0] val);
    gpio_addr = {$urandom_range(0, 32'h07FF_FFFF), ofs[2:0], 2'($urandom_range(0, 3))};
    #1;
    val = gpio_dat_o;
  endtask

  task automatic check_state(input string tag);
    logic [31:0] v;
    check({tag, ".out"}, 32'(gpio_out), m_out);
    check({tag, ".oe"}, 32'(gpio_oe), m_oe);
    check({tag, ".irq"}, 32'(gpio_int_o), 32'(m_irq));
    for (int o = 0; o < 8; o++) begin
      read(o, v);
      check($sformatf("%s.rd%0d", tag, o), v, m_read(o));
    end
  endtask

  // Called at a negedge: drive a cycle, let the edge happen, re-check at the following negedge.
  task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] data);
    gpio_we = we;
    gpio_addr = addr;
    gpio_dat_i = data;
    @(posedge sys_clk);
    m_edge();
    @(negedge sys_clk);
    gpio_we = 1'b0;
    check_state("step");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0);
  endtask

  task automatic expect_rd(input string tag, input int ofs, input logic [31:0] exp);
    logic [31:0] v;
    read(ofs, v);
    check(tag, v, exp);
  endtask

  initial begin
    mask = 32'((64'd1 << GPIO_W) - 1);
    m_reset();

    // Reset held with a write strobe and busy pads: nothing may leak through.
    gpio_we = 1'b1; gpio_addr = 32'h4; gpio_dat_i = '1; gpio_in = '1;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst.out", 32'(gpio_out), 32'h0);
    check("rst.irq", 32'(gpio_int_o), 32'h0);
    gpio_we = 1'b0;
    check_state("rst");
    gpio_in = '0;
    sys_rst = 1'b0;
    idle(1);

    // OUT / OE write and readback, reserved offset.
    step(1'b1, 32'h4, 32'h0000_00C9);
    check("out.pad", 32'(gpio_out), 32'h0000_00C9);
    step(1'b1, 32'h8, 32'hFFFF_0000);
    check("oe.pad", 32'(gpio_oe), 32'hFFFF_0000);
    step(1'b1, 32'h1C, 32'hDEAD_BEEF);
    expect_rd("rsvd", 7, 32'h0);

    // Static input pattern through the synchroniser; IN is read-only.
    gpio_in = 32'h5A5A_5A5A;
    idle(SYNC_STG);
    expect_rd("in.sync", 0, 32'h5A5A_5A5A);
    step(1'b1, 32'h0, 32'h1234_5678);
    expect_rd("in.ro", 0, 32'h5A5A_5A5A);

    // Rising edge on bit 0 with interrupt enabled.
    gpio_in = '0;
    idle(3);
    step(1'b1, 32'h0C, 32'h1);
    step(1'b1, 32'h10, 32'h1);
    step(1'b1, 32'h14, 32'h1);
    gpio_in = 32'h1;
    idle(3);
    expect_rd("rise.ints", 6, 32'h1);
    idle(1);
    check("rise.irq", 32'(gpio_int_o), 32'h1);
    expect_rd("rise.ctrl", 5, 32'h3);
    step(1'b1, 32'h18, 32'h1);
    expect_rd("w1c.ints", 6, 32'h0);
    idle(1);
    check("w1c.irq", 32'(gpio_int_o), 32'h0);

    // Falling edge on bit 4.
    gpio_in = 32'h11;
    idle(3);
    step(1'b1, 32'h0C, 32'h10);
    step(1'b1, 32'h10, 32'h0);
    gpio_in = 32'h01;
    idle(3);
    expect_rd("fall.ints", 6, 32'h10);

    // Same-cycle set and W1C on bit 0: set wins.
    step(1'b1, 32'h18, 32'hFFFF_FFFF);
    step(1'b1, 32'h0C, 32'h1);
    step(1'b1, 32'h10, 32'h1);
    gpio_in = '0;
    idle(3);
    gpio_in = 32'h1;
    idle(2);
    step(1'b1, 32'h18, 32'h1);
    expect_rd("setwins.ints", 6, 32'h1);

    // Disabled line does not latch an edge.
    step(1'b1, 32'h18, 32'h1);
    step(1'b1, 32'h0C, 32'h0);
    gpio_in = '0;
    idle(3);
    gpio_in = 32'h1;
    idle(3);
    expect_rd("inte0.ints", 6, 32'h0);

    // Global IE off masks the output but CTRL[1] still reflects pending status.
    step(1'b1, 32'h0C, 32'h1);
    gpio_in = '0;
    idle(3);
    gpio_in = 32'h1;
    idle(4);
    check("ie.irq_on", 32'(gpio_int_o), 32'h1);
    step(1'b1, 32'h14, 32'h0);
    idle(1);
    check("ie.irq_off", 32'(gpio_int_o), 32'h0);
    expect_rd("ie.ctrl", 5, 32'h2);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) gpio_in = GPIO_W'($urandom);
      else if ($urandom_range(0, 1) == 0) gpio_in = gpio_in ^ GPIO_W'(1 << $urandom_range(0, 7));
      step(1'($urandom_range(0, 1)),
           {$urandom_range(0, 32'h07FF_FFFF), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))},
           ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 255)));
    end

    // Asynchronous reset between edges with interrupts pending.
    step(1'b1, 32'h0C, 32'hF);
    step(1'b1, 32'h10, 32'hF);
    step(1'b1, 32'h14, 32'h1);
    gpio_in = '0;
    idle(3);
    step(1'b1, 32'h18, 32'hFFFF_FFFF);
    gpio_in = 32'hF;
    idle(4);
    expect_rd("pre_rst.ints", 6, 32'hF);
    check("pre_rst.irq", 32'(gpio_int_o), 32'h1);
    #10;
    sys_rst = 1'b1;
    #2;
    m_reset();
    check("arst.irq", 32'(gpio_int_o), 32'h0);
    expect_rd("arst.ints", 6, 32'h0);
    check_state("arst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
